// File: rtl/clock_training_controller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ucie_clk_train_pkg : shared states, result bit map and defaults for REPAIRCLK
// Rev 1.0
// ---------------------------------------------------------------------------
package ucie_clk_train_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_GEN = 2'd1;
  localparam logic [1:0] ST_WAIT_RX  = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    WAIT_GEN = ST_WAIT_GEN,
    WAIT_RX  = ST_WAIT_RX,
    DONE     = ST_DONE
  } state_e;

  localparam int RES_CKP   = 0;
  localparam int RES_CKN   = 1;
  localparam int RES_TRACK = 2;
  localparam int RES_W     = 3;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

  function automatic logic [RES_W-1:0] pack_result(input logic track, input logic ckn,
                                                   input logic ckp);
    logic [RES_W-1:0] r;
    r            = '0;
    r[RES_CKP]   = ckp;
    r[RES_CKN]   = ckn;
    r[RES_TRACK] = track;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_training_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_training_controller_if : LTSM / generator / RX-detector signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface clock_training_controller_if;
  import ucie_clk_train_pkg::*;

  logic             i_clk_test_req;
  logic             i_ltsm_in_reset;
  logic             i_gen_done;
  logic             i_rx_result_valid;
  logic             i_rx_ckp_ok;
  logic             i_rx_ckn_ok;
  logic             i_rx_track_ok;
  logic             o_start_clk_training;
  logic             o_busy;
  logic             o_test_done;
  logic [RES_W-1:0] o_result;
  logic             o_timeout;

  modport master (
    output i_clk_test_req, i_ltsm_in_reset, i_gen_done, i_rx_result_valid,
           i_rx_ckp_ok, i_rx_ckn_ok, i_rx_track_ok,
    input  o_start_clk_training, o_busy, o_test_done, o_result, o_timeout
  );

  modport slave (
    input  i_clk_test_req, i_ltsm_in_reset, i_gen_done, i_rx_result_valid,
           i_rx_ckp_ok, i_rx_ckn_ok, i_rx_track_ok,
    output o_start_clk_training, o_busy, o_test_done, o_result, o_timeout
  );

endinterface
`default_nettype wire

// File: rtl/clock_training_controller_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_synchronizer : multi-flop synchronizer for a single asynchronous level
// Rev 1.0
// ---------------------------------------------------------------------------
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clock_training_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_training_controller : TX-side REPAIRCLK clock-pattern training sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module clock_training_controller
  import ucie_clk_train_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                        i_dig_clk,
  input  logic                        i_rst_n,
  clock_training_controller_if.slave  bus
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [RES_W-1:0] result_q, result_d;

  logic             gen_done_s;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_sat;
  logic             clear;
  logic             fin_timeout;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_gen_done_sync (
    .clk_i  (i_dig_clk),
    .rst_ni (i_rst_n),
    .d_i    (bus.i_gen_done),
    .q_o    (gen_done_s)
  );

  // Counter spans both wait states and parks at the last value instead of wrapping.
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign cnt_sat     = timeout_hit ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = start_q;
    busy_d      = busy_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    result_d    = result_q;
    clear       = 1'b0;
    fin_timeout = 1'b0;

    if (bus.i_ltsm_in_reset) begin
      clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // A still-high done means the generator has not cleared from the previous run.
          if (bus.i_clk_test_req && !gen_done_s) begin
            state_d = WAIT_GEN;
            cnt_d   = '0;
            start_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        WAIT_GEN: begin
          if (!bus.i_clk_test_req) begin
            clear = 1'b1;
          end else if (gen_done_s) begin
            state_d = WAIT_RX;
            cnt_d   = cnt_sat;
          end else if (timeout_hit) begin
            fin_timeout = 1'b1;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        WAIT_RX: begin
          if (!bus.i_clk_test_req) begin
            clear = 1'b1;
          end else if (bus.i_rx_result_valid) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b0;
            result_d  = pack_result(bus.i_rx_track_ok, bus.i_rx_ckn_ok, bus.i_rx_ckp_ok);
          end else if (timeout_hit) begin
            fin_timeout = 1'b1;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        DONE: begin
          if (!bus.i_clk_test_req) begin
            clear = 1'b1;
          end
        end
        default: clear = 1'b1;
      endcase
    end

    if (fin_timeout) begin
      state_d   = DONE;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      result_d  = '0;
    end

    if (clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      start_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      result_d  = '0;
    end
  end

  assign bus.o_start_clk_training = start_q;
  assign bus.o_busy               = busy_q;
  assign bus.o_test_done          = done_q;
  assign bus.o_timeout            = timeout_q;
  assign bus.o_result             = result_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_training_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clock_training_controller : two DUTs (timeout 1024 and 64) against a scenario model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_clock_training_controller;
  import ucie_clk_train_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, ltsm = 1'b0, gdone = 1'b0, valid = 1'b0;
  logic ckp = 1'b0, ckn = 1'b0, trk = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  clock_training_controller_if ifa ();
  clock_training_controller_if ifb ();

  assign ifa.i_clk_test_req    = req;
  assign ifa.i_ltsm_in_reset   = ltsm;
  assign ifa.i_gen_done        = gdone;
  assign ifa.i_rx_result_valid = valid;
  assign ifa.i_rx_ckp_ok       = ckp;
  assign ifa.i_rx_ckn_ok       = ckn;
  assign ifa.i_rx_track_ok     = trk;
  assign ifb.i_clk_test_req    = req;
  assign ifb.i_ltsm_in_reset   = ltsm;
  assign ifb.i_gen_done        = gdone;
  assign ifb.i_rx_result_valid = valid;
  assign ifb.i_rx_ckp_ok       = ckp;
  assign ifb.i_rx_ckn_ok       = ckn;
  assign ifb.i_rx_track_ok     = trk;

  clock_training_controller #(.TIMEOUT_CYCLES(1024), .SYNC_STAGES(2)) dut_a (
    .i_dig_clk (clk), .i_rst_n (rst_n), .bus (ifa.slave));
  clock_training_controller #(.TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut_b (
    .i_dig_clk (clk), .i_rst_n (rst_n), .bus (ifb.slave));

  // Scenario model: phase 0 idle, 1 awaiting generator, 2 awaiting RX, 3 finished;
  // n counts edges since the test started.
  typedef struct packed {
    int         ph;
    int         n;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] res;
    logic       to;
  } mdl_t;

  mdl_t       ma, mb;
  logic [1:0] msync;

  function automatic mdl_t mstep(input mdl_t m, input int lim, input logic gds);
    mdl_t r;
    r = m;
    if (ltsm || (m.ph != 0 && !req)) return '0;
    if (m.ph == 0) begin
      if (req && !gds) begin
        r = '0; r.ph = 1; r.start = 1'b1; r.busy = 1'b1;
      end
    end else if (m.ph == 1 || m.ph == 2) begin
      if (m.ph == 1 && gds) begin
        r.ph = 2; r.n = m.n + 1;
      end else if (m.ph == 2 && valid) begin
        r.ph = 3; r.busy = 1'b0; r.done = 1'b1; r.res = {trk, ckn, ckp}; r.to = 1'b0;
      end else if (m.n >= lim - 1) begin
        r.ph = 3; r.busy = 1'b0; r.done = 1'b1; r.res = 3'b000; r.to = 1'b1;
      end else begin
        r.n = m.n + 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0; mb <= '0; msync <= 2'b00;
    end else begin
      ma    <= mstep(ma, 1024, msync[1]);
      mb    <= mstep(mb, 64, msync[1]);
      msync <= {msync[0], gdone};
    end
  end

  logic [13:0] exp_v, obs_v;
  assign exp_v = {ma.start, ma.busy, ma.done, ma.res, ma.to,
                  mb.start, mb.busy, mb.done, mb.res, mb.to};
  assign obs_v = {ifa.o_start_clk_training, ifa.o_busy, ifa.o_test_done, ifa.o_result, ifa.o_timeout,
                  ifb.o_start_clk_training, ifb.o_busy, ifb.o_test_done, ifb.o_result, ifb.o_timeout};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) begin
      tick();
      total++;
      if (obs_v !== 14'b0) begin
        bad++; $display("FAIL reset_outputs got=%b want=%b", obs_v, 14'b0);
      end
    end
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL reset_idle got=%b want=%b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_basic_pass();
    req = 1'b1;
    tick();
    total++;
    if (ifa.o_start_clk_training !== 1'b1) begin
      bad++; $display("FAIL start_latency got=%b want=1", ifa.o_start_clk_training);
    end
    for (int c = 1; c < 195; c++) begin
      if (c == 180) gdone = 1'b1;
      if (c == 185) begin valid = 1'b1; {trk, ckn, ckp} = 3'b111; end
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL basic_pass c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
    total++;
    if ({ifa.o_test_done, ifa.o_result, ifa.o_timeout} !== 5'b1_111_0) begin
      bad++; $display("FAIL basic_pass_result got=%b want=%b",
                      {ifa.o_test_done, ifa.o_result, ifa.o_timeout}, 5'b1_111_0);
    end
    total++;
    if ({ifb.o_test_done, ifb.o_timeout} !== 2'b11) begin
      bad++; $display("FAIL basic_pass_short_timeout got=%b want=11", {ifb.o_test_done, ifb.o_timeout});
    end
    req = 1'b0; gdone = 1'b0; valid = 1'b0;
    tick();
    total++;
    if (obs_v !== 14'b0) begin
      bad++; $display("FAIL basic_release got=%b want=%b", obs_v, 14'b0);
    end
    repeat (4) tick();
  endtask

  task automatic test_result_patterns();
    for (int it = 0; it < 6; it++) begin
      int gd, vd;
      logic [2:0] bits;
      gd   = int'($urandom_range(3, 40));
      vd   = gd + int'($urandom_range(0, 12));
      bits = (it == 0) ? 3'b011 : 3'($urandom);
      for (int c = 0; c < vd + 6; c++) begin
        if (c == 0)  req = 1'b1;
        if (c == gd) gdone = 1'b1;
        if (c == vd) begin valid = 1'b1; {trk, ckn, ckp} = bits; end
        tick();
        total++;
        if (obs_v !== exp_v) begin
          bad++; $display("FAIL pattern it=%0d c=%0d got=%b want=%b", it, c, obs_v, exp_v);
        end
      end
      total++;
      if ({ifa.o_test_done, ifa.o_result, ifa.o_timeout} !== {1'b1, bits, 1'b0}) begin
        bad++; $display("FAIL pattern_result it=%0d got=%b want=%b", it,
                        {ifa.o_test_done, ifa.o_result, ifa.o_timeout}, {1'b1, bits, 1'b0});
      end
      req = 1'b0; gdone = 1'b0; valid = 1'b0;
      repeat (4) begin
        tick();
        total++;
        if (obs_v !== exp_v) begin
          bad++; $display("FAIL pattern_release it=%0d got=%b want=%b", it, obs_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int first_done;
    first_done = -1;
    for (int c = 0; c < 80; c++) begin
      if (c == 0) req = 1'b1;
      tick();
      if (ifb.o_test_done === 1'b1 && first_done < 0) first_done = c;
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL timeout c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
    total++;
    if (first_done != 64) begin
      bad++; $display("FAIL timeout_cycle got=%0d want=64", first_done);
    end
    total++;
    if ({ifb.o_timeout, ifb.o_result, ifa.o_busy} !== 5'b1_000_1) begin
      bad++; $display("FAIL timeout_flags got=%b want=%b",
                      {ifb.o_timeout, ifb.o_result, ifa.o_busy}, 5'b1_000_1);
    end
    req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_timeout_race();
    logic [2:0] bits;
    bits = 3'($urandom);
    for (int c = 0; c < 70; c++) begin
      if (c == 0)  req = 1'b1;
      if (c == 62) begin gdone = 1'b1; valid = 1'b1; {trk, ckn, ckp} = bits; end
      tick();
      if (c == 64) begin
        total++;
        if ({ifb.o_busy, ifb.o_test_done} !== 2'b10) begin
          bad++; $display("FAIL race_entry got=%b want=10", {ifb.o_busy, ifb.o_test_done});
        end
      end
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL race c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
    total++;
    if ({ifb.o_test_done, ifb.o_result, ifb.o_timeout} !== {1'b1, bits, 1'b0}) begin
      bad++; $display("FAIL race_result got=%b want=%b",
                      {ifb.o_test_done, ifb.o_result, ifb.o_timeout}, {1'b1, bits, 1'b0});
    end
    req = 1'b0; gdone = 1'b0; valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_abort();
    logic seen_done;
    seen_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0)  req = 1'b1;
      if (c == 5)  gdone = 1'b1;
      if (c == 15) ltsm = 1'b1;
      if (c == 16) ltsm = 1'b0;
      tick();
      seen_done |= ifa.o_test_done | ifb.o_test_done;
      if (c == 15) begin
        total++;
        if ({ifa.o_start_clk_training, ifa.o_busy} !== 2'b00) begin
          bad++; $display("FAIL ltsm_abort got=%b want=00", {ifa.o_start_clk_training, ifa.o_busy});
        end
      end
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL abort_ltsm c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
    req = 1'b0; gdone = 1'b0;
    repeat (4) tick();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) req = 1'b1;
      if (c == 6) req = 1'b0;
      tick();
      seen_done |= ifa.o_test_done | ifb.o_test_done;
      if (c == 6) begin
        total++;
        if ({ifa.o_start_clk_training, ifa.o_busy} !== 2'b00) begin
          bad++; $display("FAIL req_abort got=%b want=00", {ifa.o_start_clk_training, ifa.o_busy});
        end
      end
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL abort_req c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++; $display("FAIL abort_no_done got=%b want=0", seen_done);
    end
  endtask

  task automatic test_stale_gen_done();
    gdone = 1'b1;
    repeat (4) tick();
    req = 1'b1;
    repeat (5) begin
      tick();
      total++;
      if (ifa.o_start_clk_training !== 1'b0 || obs_v !== exp_v) begin
        bad++; $display("FAIL stale_hold got=%b want=%b", obs_v, exp_v);
      end
    end
    gdone = 1'b0;
    repeat (6) begin
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL stale_release got=%b want=%b", obs_v, exp_v);
      end
    end
    total++;
    if (ifa.o_start_clk_training !== 1'b1) begin
      bad++; $display("FAIL stale_start got=%b want=1", ifa.o_start_clk_training);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_v !== 14'b0 || exp_v !== 14'b0) begin
      bad++; $display("FAIL async_reset got=%b want=%b", obs_v, 14'b0);
    end
    tick();
    req = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL post_reset got=%b want=%b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 8; it++) begin
      int gd, vd, kind, ab;
      gd   = int'($urandom_range(2, 70));
      vd   = gd + int'($urandom_range(0, 8));
      kind = int'($urandom_range(0, 3));
      ab   = int'($urandom_range(1, vd + 4));
      for (int c = 0; c < vd + 8; c++) begin
        if (c == 0) req = 1'b1;
        if (c == gd) gdone = 1'b1;
        if (c == vd) begin valid = 1'b1; {trk, ckn, ckp} = 3'($urandom); end
        if (kind == 0 && c == ab)     ltsm = 1'b1;
        if (kind == 0 && c == ab + 1) ltsm = 1'b0;
        if (kind == 1 && c == ab)     req = 1'b0;
        tick();
        total++;
        if (obs_v !== exp_v) begin
          bad++; $display("FAIL b2b it=%0d c=%0d got=%b want=%b", it, c, obs_v, exp_v);
        end
      end
      req = 1'b0; gdone = 1'b0; valid = 1'b0; ltsm = 1'b0;
      repeat (int'($urandom_range(1, 4))) begin
        tick();
        total++;
        if (obs_v !== exp_v) begin
          bad++; $display("FAIL b2b_gap it=%0d got=%b want=%b", it, obs_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_result_patterns();
    test_timeout();
    test_timeout_race();
    test_abort();
    test_stale_gen_done();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
